// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the integer multiply/divide unit: operation codes,
// FSM states and the default operand width.
package muldiv_unit_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result handshake bundle for muldiv_unit; the unit sits on the slave side.
interface muldiv_unit_if
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);

   logic            in_valid;
   logic            in_ready;
   mul_op_t         op;
   logic [XLEN-1:0] r1;
   logic [XLEN-1:0] r2;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] rd;

   modport master (
      output in_valid, op, r1, r2, kill, out_ready,
      input  in_ready, out_valid, rd
   );

   modport slave (
      input  in_valid, op, r1, r2, kill, out_ready,
      output in_ready, out_valid, rd
   );

endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Shared {hi,lo} accumulator and step counter: radix-2 restoring divide or
// shift-add multiply, one bit per step; also supports in-place negate and parallel load.
module div_iter
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              start,
   input  logic              mul_mode,
   input  logic              step,
   input  logic              negate,
   input  logic              load,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic [2*XLEN-1:0] load_val,
   output logic [XLEN-1:0]   hi,
   output logic [XLEN-1:0]   lo,
   output logic              last
);

   localparam int CW = $clog2(XLEN) + 1;

   logic [XLEN-1:0] hi_q, lo_q, b_q;
   logic [CW-1:0]   cnt_q;
   logic            mul_q;
   logic [XLEN:0]   sum, rem_sh, diff;

   // Multiply: hi accumulates the multiplicand, product shifts right through lo.
   // Divide: partial remainder in hi, dividend shifts out of lo as quotient shifts in.
   always_comb begin
      sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rem_sh = {hi_q, lo_q[XLEN-1]};
      diff   = rem_sh - {1'b0, b_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         mul_q <= 1'b0;
      end else if (clr) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         mul_q <= 1'b0;
      end else if (start) begin
         hi_q  <= '0;
         lo_q  <= a;
         b_q   <= b;
         cnt_q <= '0;
         mul_q <= mul_mode;
      end else if (load) begin
         {hi_q, lo_q} <= load_val;
      end else if (negate) begin
         {hi_q, lo_q} <= -{hi_q, lo_q};
      end else if (step) begin
         cnt_q <= cnt_q + CW'(1);
         if (mul_q) begin
            hi_q <= sum[XLEN:1];
            lo_q <= {sum[0], lo_q[XLEN-1:1]};
         end else if (!diff[XLEN]) begin
            hi_q <= diff[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_q <= rem_sh[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b0};
         end
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign last = (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV-style MUL/DIV unit: XLEN-step divide, XLEN(+1 sign-fix) step multiply, or 1-cycle
// multiply with MULDIV_FAST_MUL_EN; result held in DONE until out_ready, kill aborts.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state_q, state_n;
   mul_op_t         op_q;
   logic [XLEN-1:0] spec_q;
   logic            special_q, qneg_q, rneg_q, fix_q;

   logic            op_div, sdiv, neg1, neg2, dz, ovf;
   logic [XLEN-1:0] mag1, mag2, spec_val;
   logic            iter_start, iter_step, iter_neg, iter_load, fix_set, iter_last;
   logic [XLEN-1:0] iter_hi, iter_lo, res;
   logic [2*XLEN-1:0] load_val;

   // Request decode: magnitudes for the iterative datapath and the 1-cycle special results.
   always_comb begin
      op_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU) ||
               (bus.op == OP_REM) || (bus.op == OP_REMU);
      sdiv   = (bus.op == OP_DIV) || (bus.op == OP_REM);
      neg1   = (sdiv || bus.op == OP_MULH || bus.op == OP_MULHSU) && bus.r1[XLEN-1];
      neg2   = (sdiv || bus.op == OP_MULH) && bus.r2[XLEN-1];
      mag1   = neg1 ? -bus.r1 : bus.r1;
      mag2   = neg2 ? -bus.r2 : bus.r2;
      dz     = (bus.r2 == '0);
      ovf    = sdiv && (bus.r1 == MIN_VAL) && (bus.r2 == '1);
      if (dz)
         spec_val = (bus.op == OP_DIV || bus.op == OP_DIVU) ? '1 : bus.r1;
      else
         spec_val = (bus.op == OP_DIV) ? bus.r1 : '0;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [XLEN-1:0]   r1_q, r2_q;
   logic [2*XLEN-1:0] a_ext, b_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_q <= '0;
         r2_q <= '0;
      end else if (iter_start) begin
         r1_q <= bus.r1;
         r2_q <= bus.r2;
      end
   end

   always_comb begin
      a_ext = (op_q == OP_MULH || op_q == OP_MULHSU) ? {{XLEN{r1_q[XLEN-1]}}, r1_q}
                                                     : {{XLEN{1'b0}}, r1_q};
      b_ext = (op_q == OP_MULH) ? {{XLEN{r2_q[XLEN-1]}}, r2_q} : {{XLEN{1'b0}}, r2_q};
      load_val = a_ext * b_ext;
   end
`else
   assign load_val = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= OP_MUL;
         spec_q    <= '0;
         special_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         fix_q     <= 1'b0;
      end else begin
         state_q <= state_n;
         fix_q   <= (state_n == MUL) && (fix_q || fix_set);
         if (iter_start) begin
            op_q      <= bus.op;
            spec_q    <= spec_val;
            special_q <= op_div && (dz || ovf);
            qneg_q    <= neg1 ^ neg2;
            rneg_q    <= sdiv && neg1;
         end
      end
   end

   always_comb begin
      state_n    = state_q;
      iter_start = 1'b0;
      iter_step  = 1'b0;
      iter_neg   = 1'b0;
      iter_load  = 1'b0;
      fix_set    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               iter_start = 1'b1;
               state_n    = op_div ? DIV : MUL;
            end
         end
         MUL: begin
`ifdef MULDIV_FAST_MUL_EN
            iter_load = 1'b1;
            state_n   = DONE;
`else
            if (fix_q) begin
               iter_neg = qneg_q;
               state_n  = DONE;
            end else begin
               iter_step = 1'b1;
               if (iter_last) begin
                  if (op_q == OP_MULH || op_q == OP_MULHSU)
                     fix_set = 1'b1;
                  else
                     state_n = DONE;
               end
            end
`endif
         end
         DIV: begin
            // Divide-by-zero and signed overflow skip the iteration entirely.
            if (special_q) begin
               state_n = DONE;
            end else begin
               iter_step = 1'b1;
               if (iter_last)
                  state_n = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (bus.kill) begin
         state_n    = IDLE;
         iter_start = 1'b0;
         iter_step  = 1'b0;
         iter_neg   = 1'b0;
         iter_load  = 1'b0;
         fix_set    = 1'b0;
      end
   end

   div_iter #(.XLEN(XLEN)) u_div_iter (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.kill),
      .start    (iter_start),
      .mul_mode (!op_div),
      .step     (iter_step),
      .negate   (iter_neg),
      .load     (iter_load),
      .a        (mag1),
      .b        (mag2),
      .load_val (load_val),
      .hi       (iter_hi),
      .lo       (iter_lo),
      .last     (iter_last)
   );

   always_comb begin
      res = '0;
      case (op_q)
         OP_MUL:                       res = iter_lo;
         OP_MULH, OP_MULHSU, OP_MULHU: res = iter_hi;
         OP_DIV, OP_DIVU:              res = special_q ? spec_q : (qneg_q ? -iter_lo : iter_lo);
         OP_REM, OP_REMU:              res = special_q ? spec_q : (rneg_q ? -iter_hi : iter_hi);
         default:                      res = '0;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.rd        = (state_q == DONE) ? res : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at XLEN=32: directed table, handshake/kill/reset sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int ML  = 1;
   localparam int MLH = 1;
`else
   localparam int ML  = 32;
   localparam int MLH = 33;
`endif

   typedef struct {
      mul_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   muldiv_unit_if #(.XLEN(32)) bus ();
   muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", nm, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_rd(mul_op_t o, logic [31:0] a, logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = '0;
      case (o)
         OP_MUL:    begin p = ua * ub; return p[31:0];  end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            p = sa / sb; return p[31:0];
         end
         OP_DIVU: begin
            if (b == 0) return 32'hFFFFFFFF;
            p = ua / ub; return p[31:0];
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         OP_REMU: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(mul_op_t o, logic [31:0] a, logic [31:0] b);
      case (o)
         OP_MUL, OP_MULHU:   return ML;
         OP_MULH, OP_MULHSU: return MLH;
         OP_DIV, OP_REM:     return (b == 0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 32;
         default:            return (b == 0) ? 1 : 32;
      endcase
   endfunction

   // Issue one request; lat = edges from the accept edge until out_valid is seen.
   task automatic do_op(input mul_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.r1       = a;
      bus.r2       = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.r1       = $urandom;
      bus.r2       = $urandom;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.rd;
      if (bus.out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vec_t        tbl[14];
      logic [31:0] res, hold_rd;
      int          lat;
      logic        ok, seen;

      tbl[0]  = '{OP_MUL,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, ML};
      tbl[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'd2,        32'h00000001, ML};
      tbl[2]  = '{OP_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MLH};
      tbl[3]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
      tbl[4]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32};
      tbl[5]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
      tbl[6]  = '{OP_REMU,   32'd5,        32'd0,        32'd5,        1};
      tbl[7]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      tbl[8]  = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
      tbl[9]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MLH};
      tbl[10] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32};
      tbl[11] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        32};
      tbl[12] = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       32};
      tbl[13] = '{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32};

      bus.in_valid  = 1'b0;
      bus.op        = OP_MUL;
      bus.r1        = '0;
      bus.r2        = '0;
      bus.kill      = 1'b0;
      bus.out_ready = 1'b1;

      #2;
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset rd", bus.rd, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (tbl[i]) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
         chk($sformatf("vec%0d rd", i), res, tbl[i].exp);
         chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      end

      // Result held while the consumer stalls.
      bus.out_ready = 1'b0;
      do_op(OP_DIV, 32'd1000, 32'hFFFFFFFD, hold_rd, lat);
      chk("stall rd", hold_rd, 32'hFFFFFEB3);
      ok = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b1 || bus.rd !== 32'hFFFFFEB3 || bus.in_ready !== 1'b0) ok = 1'b0;
      end
      chk("stall stable", ok, 1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("consume in_ready", bus.in_ready, 1);
      chk("consume out_valid", bus.out_valid, 0);

      // Kill at cycle 10 of a divide.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.r1 = 32'd1000; bus.r2 = 32'd3;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.kill = 1'b1;
      @(posedge clk);
      #1 bus.kill = 1'b0;
      chk("kill in_ready", bus.in_ready, 1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("kill no result", seen, 0);

      // Reset in the middle of a divide.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = OP_DIV; bus.r1 = 32'd12345; bus.r2 = 32'd11;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst in_ready", bus.in_ready, 1);
      chk("rst out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("rst no result", seen, 0);

      // Second reset mid-divide; request on the very first edge after release.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = OP_REM; bus.r1 = 32'd999; bus.r2 = 32'd10;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      do_op(OP_DIVU, 32'd5, 32'd0, res, lat);
      chk("post-rst rd", res, 32'hFFFFFFFF);
      chk("post-rst latency", lat, 1);

      for (int n = 0; n < 300; n++) begin
         mul_op_t     o;
         logic [31:0] a, b;
         int          sel;
         o   = mul_op_t'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = $urandom_range(1, 15);
            3: a = $urandom_range(0, 255);
            4: b = -$urandom_range(1, 15);
            default: ;
         endcase
         do_op(o, a, b, res, lat);
         chk($sformatf("rand%0d %s rd", n, o.name()), res, ref_rd(o, a, b));
         chk($sformatf("rand%0d %s latency", n, o.name()), lat, ref_lat(o, a, b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 SHALL have ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- op  input  mul_op_t  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- r1  input  XLEN  rs1 operand.
- r2  input  XLEN  rs2 operand.
- kill  input  1  abort the in-flight operation.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- rd  output  XLEN  result.

Function
REQ-003 SHALL accept a request when in_valid && in_ready on a clk edge, latching op, r1 and r2; inputs are ignored at all other times.
REQ-004 SHALL implement FSM states IDLE, MUL, DIV, DONE; in_ready is 1 only in IDLE.
REQ-005 SHALL transition IDLE->MUL on an accepted MUL* op and IDLE->DIV on an accepted DIV/REM op.
REQ-006 SHALL run an iterative radix-2 restoring divider on operand magnitudes in DIV for exactly XLEN cycles, then go to DONE; out_valid rises XLEN+1 edges after the accept edge.
REQ-007 SHALL sign-correct the result for DIV/REM: quotient negative iff operand signs differ, remainder takes the dividend's sign.
REQ-008 SHALL, for divide by zero, return all-ones for DIV/DIVU and r1 for REM/REMU, completing in 1 cycle (IDLE->DONE bypassing DIV).
REQ-009 SHALL, for signed overflow (r1 = most-negative, r2 = -1), return r1 for DIV and 0 for REM, completing in 1 cycle.
REQ-010 SHALL compute products at 2*XLEN bits: MUL low half; MULH signed x signed high; MULHSU signed r1 x unsigned r2 high; MULHU unsigned x unsigned high.
REQ-011 SHALL hold out_valid and rd stable in DONE until out_ready; on out_valid && out_ready, return to IDLE.
REQ-012 SHALL not accept a new request in the same cycle a result is consumed (IDLE required first).
REQ-013 SHALL, on kill=1, return to IDLE at the next edge from any state, drop any pending result and deassert out_valid; kill takes priority over accept and completion.
REQ-014 SHALL keep rd at 0 whenever out_valid=0.

Reset
REQ-015 SHALL asynchronously force state=IDLE, in_ready=1, out_valid=0, rd=0 and clear all internal registers while rst=1.
REQ-016 SHALL discard any in-flight operation on reset mid-operation; no result appears after reset release.
REQ-017 SHALL accept a request on the first edge after rst deasserts.

Configuration
REQ-018 SHALL use macro MULDIV_FAST_MUL_EN.
REQ-019 SHALL, with MULDIV_FAST_MUL_EN defined, compute the product with a single-cycle array multiplier: MUL lasts 1 cycle, out_valid rises 2 edges after accept.
REQ-020 SHALL, without MULDIV_FAST_MUL_EN, use an iterative shift-add multiplier sharing the divider's accumulator/counter: MUL lasts XLEN cycles, out_valid rises XLEN+1 edges after accept, plus 1 sign-fix cycle for MULH/MULHSU folded into the MUL state count.
REQ-021 SHALL produce bit-identical results in both configurations.

Structure
REQ-022 SHALL take mul_op_t, XLEN default and state-enum typedef from the shared defs package; no local redefinition of mul_op_t.
REQ-023 SHALL place the divider datapath (remainder/quotient shift registers, iteration counter) in one sub-module, div_iter; the FSM, multiplier and handshake stay in muldiv_unit.

Verification
REQ-024 SHALL cover, at XLEN=32:
- MUL r1=0xFFFFFFFF, r2=2 -> rd=0xFFFFFFFE; MULHU same -> rd=0x00000001; MULH same -> rd=0xFFFFFFFF.
- DIV r1=-7, r2=2 -> rd=0xFFFFFFFD (-3), out_valid 33 edges after accept; REM same -> rd=0xFFFFFFFF (-1).
- DIVU r1=5, r2=0 -> rd=0xFFFFFFFF and REMU -> rd=5, each 2 edges after accept; DIV 0x80000000 / 0xFFFFFFFF -> rd=0x80000000.
- out_ready held 0 for 10 cycles in DONE -> rd and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge.
- kill at cycle 10 of a DIV -> out_valid never asserts, in_ready=1 next edge; same for rst mid-DIV.
- MULHSU r1=0xFFFFFFFF, r2=0xFFFFFFFF -> rd=0xFFFFFFFF, with and without MULDIV_FAST_MUL_EN, with the latency of REQ-019/REQ-020.
